feedback_sample_scheduler: RTL and testbench
============================================

# feedback_sample_scheduler

Time-multiplexes one shared dual-edge feedback sampler among `NCH` cochlea channel requesters. The block arbitrates round-robin, steers the sampler's input select, and pulses the sampler's clear. It then gates sampling for a fixed window, accumulates the sampled feedback bit, and returns a per-channel count with a one-cycle done strobe. It sits between the channel feedback logic and the shared sampler/mux in the feedback path.

## Interface
- `NCH`, 8, number of requesting channels (2..16)
- `SAMPLE_CYCLES`, 4, length of the sampling window in `clk` cycles (1..2^`CW`-1)
- `CW`, 8, width of the accumulated count
- `clk` input 1, single rising-edge clock for all state
- `rst` input 1, asynchronous, active-high reset
- `req` input `NCH`, per-channel sample request, level; held until the matching `grant` bit pulses
- `samp_q` input 1, sampled feedback bit returned by the shared dual-edge sampler
- `sel` output `$clog2(NCH)`, channel index driving the sampler input mux
- `samp_clr` output 1, one-cycle clear pulse to the sampler before each window
- `samp_en` output 1, high for exactly `SAMPLE_CYCLES` cycles per window
- `grant` output `NCH`, one-hot, one-cycle pulse to the serviced channel, coincident with `done`
- `done` output 1, one-cycle strobe; `result` is valid in the same cycle
- `result` output `CW`, count of cycles in the window with `samp_q`=1
- `busy` output 1, high in every state except IDLE

## Operation
- FSM states: IDLE, CLEAR, SAMPLE, REPORT.
- IDLE:
  - If `|req` is 0, stay in IDLE.
  - Otherwise the round-robin arbiter picks the first set `req` bit at or after `ptr` (wrapping modulo `NCH`). The winner is registered into `sel`, and the FSM moves to CLEAR.
- CLEAR: `samp_clr`=1 for one cycle; the count is zeroed; move to SAMPLE.
- SAMPLE:
  - `samp_en`=1.
  - Each cycle, `count += samp_q`.
  - The window counter runs 0..`SAMPLE_CYCLES`-1. At the last value, move to REPORT.
- REPORT:
  - `done`=1 and `grant[sel]`=1; `result` holds the count.
  - `ptr` is set to `sel`+1, wrapping from `NCH`-1 to 0.
  - Move to IDLE.
- `sel` and `result` hold their values until the next arbitration or the next REPORT.
- A requester that does not drop `req` after its `grant` is re-arbitrated fairly; it cannot starve other channels.
- A `req` asserted mid-window is not observed until the next IDLE.
- Reset values:
  - State IDLE.
  - `ptr`=0.
  - `sel`, `samp_clr`, `samp_en`, `grant`, `done`, `result`, `busy` all 0.
- Reset mid-window aborts the window immediately. No `done` or `grant` is issued, and the aborted channel keeps its priority only through `ptr`=0.

## Timing
- `req` seen at edge k: CLEAR in cycle k+1, SAMPLE in cycles k+2..k+1+`SAMPLE_CYCLES`, REPORT (`done`) in cycle k+2+`SAMPLE_CYCLES`.
- Earliest next CLEAR is cycle k+4+`SAMPLE_CYCLES`, because IDLE lasts at least one cycle.
- `sel` is stable from CLEAR through REPORT. It never changes while `samp_en`=1.
- `samp_q` is captured on the rising edge ending each SAMPLE cycle. The sampler's own dual-edge behaviour is invisible to this block.

## Configuration
- `FB_SCHED_SAT_EN` defined: `count` saturates at 2^`CW`-1.
- `FB_SCHED_SAT_EN` undefined: `count` wraps modulo 2^`CW`.
- With legal parameters (`SAMPLE_CYCLES` ≤ 2^`CW`-1) the two builds are identical. The macro only affects over-range parameterisation used in characterisation builds.

## Structure
- `fb_sched_pkg` holds:
  - the state enum (IDLE, CLEAR, SAMPLE, REPORT);
  - the default constants `NCH`, `SAMPLE_CYCLES`, `CW`;
  - the `sel` width function.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req` and `ptr`. It outputs the winner index and an any-valid flag. `ptr` itself stays registered in the parent.

## Test plan
- Reset, then `req`=0 for 20 cycles -> all outputs stay 0 and `busy`=0.
- `req`=8'b0000_0100 at edge 0, `samp_q`=1 for the whole window, `SAMPLE_CYCLES`=4 -> `sel`=2 from cycle 1, `samp_clr` in cycle 1, `samp_en` in cycles 2–5, `done` with `result`=4 and `grant`=8'b0000_0100 in cycle 6.
- `req`=8'hFF held -> grants in order 0,1,2,…,7,0, one every 7 cycles, no channel repeats before all others are serviced.
- `samp_q` pattern 1,0,1,1 across the window for channel 5 -> `result`=3, `grant[5]`=1.
- `rst` asserted in cycle 3 of a window -> outputs go to 0 asynchronously, no `done`. After release with `req`=8'b1000_0001, channel 0 is serviced first.
- `FB_SCHED_SAT_EN` build with `CW`=2, `SAMPLE_CYCLES`=5, `samp_q`=1 -> `result`=3. Without the macro -> `result`=1 (wrap).

Source files
------------

// File: rtl/fb_sched_pkg.sv
// Shared types and defaults for the feedback sample scheduler.
package fb_sched_pkg;

  localparam int unsigned FB_NCH           = 8;
  localparam int unsigned FB_SAMPLE_CYCLES = 4;
  localparam int unsigned FB_CW            = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } fb_state_e;

  // Index width for n items, never below one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/feedback_sample_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping modulo NCH.
module rr_arbiter
  import fb_sched_pkg::*;
#(
  parameter int unsigned NCH = FB_NCH,
  localparam int unsigned SW = sel_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic [SW-1:0]  idx_c,
  output logic           valid_c
);

  localparam int unsigned SW1 = SW + 1;

  logic [SW:0] cand_c;

  // Scan candidates starting at ptr; ptr < NCH so one wrap subtraction suffices.
  always_comb begin
    idx_c   = '0;
    valid_c = 1'b0;
    cand_c  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand_c = {1'b0, ptr} + SW1'(i);
      if (cand_c >= SW1'(NCH)) cand_c = cand_c - SW1'(NCH);
      if (!valid_c && req[cand_c[SW-1:0]]) begin
        valid_c = 1'b1;
        idx_c   = cand_c[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/feedback_sample_scheduler.sv
// Shares one dual-edge feedback sampler among NCH channels: round-robin
// arbitration, clear pulse, fixed sampling window, per-channel count report.
// Build option: FB_SCHED_SAT_EN makes the count saturate instead of wrap.
module feedback_sample_scheduler
  import fb_sched_pkg::*;
#(
  parameter int unsigned NCH           = FB_NCH,
  parameter int unsigned SAMPLE_CYCLES = FB_SAMPLE_CYCLES,
  parameter int unsigned CW            = FB_CW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req,
  input  logic                    samp_q,
  output logic [sel_w(NCH)-1:0]   sel,
  output logic                    samp_clr,
  output logic                    samp_en,
  output logic [NCH-1:0]          grant,
  output logic                    done,
  output logic [CW-1:0]           result,
  output logic                    busy
);

  localparam int unsigned SW = sel_w(NCH);
  localparam int unsigned WW = sel_w(SAMPLE_CYCLES);

  fb_state_e         state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [SW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     win_q, win_d;
  logic [CW-1:0]     result_q, result_d;
  logic [NCH-1:0]    grant_q, grant_d;
  logic              done_q, done_d;
  logic              samp_clr_q, samp_clr_d;
  logic              samp_en_q, samp_en_d;
  logic              busy_q, busy_d;

  logic [SW-1:0]     arb_idx_c;
  logic              arb_valid_c;
  logic [CW-1:0]     cnt_inc_c;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .idx_c   (arb_idx_c),
    .valid_c (arb_valid_c)
  );

  // Count plus the current sample, saturating or wrapping per build option.
  always_comb begin
`ifdef FB_SCHED_SAT_EN
    cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CW'(samp_q);
`else
    cnt_inc_c = cnt_q + CW'(samp_q);
`endif
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    result_d = result_q;
    grant_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid_c) begin
          sel_d   = arb_idx_c;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        win_d   = '0;
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        cnt_d = cnt_inc_c;
        if (win_q == WW'(SAMPLE_CYCLES - 1)) begin
          result_d = cnt_inc_c;
          grant_d  = NCH'(1) << sel_q;
          state_d  = ST_REPORT;
        end else begin
          win_d = win_q + WW'(1);
        end
      end
      ST_REPORT: begin
        ptr_d   = (sel_q == SW'(NCH - 1)) ? '0 : sel_q + SW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    samp_clr_d = (state_d == ST_CLEAR);
    samp_en_d  = (state_d == ST_SAMPLE);
    done_d     = (state_d == ST_REPORT);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any window in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      win_q      <= '0;
      result_q   <= '0;
      grant_q    <= '0;
      done_q     <= 1'b0;
      samp_clr_q <= 1'b0;
      samp_en_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      result_q   <= result_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      samp_clr_q <= samp_clr_d;
      samp_en_q  <= samp_en_d;
      busy_q     <= busy_d;
    end
  end

  assign sel      = sel_q;
  assign samp_clr = samp_clr_q;
  assign samp_en  = samp_en_q;
  assign grant    = grant_q;
  assign done     = done_q;
  assign result   = result_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_feedback_sample_scheduler.sv
// Scoreboard bench for feedback_sample_scheduler (default build and FB_SCHED_SAT_EN build).
module tb_feedback_sample_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic        samp_q;
  logic [2:0]  sel;
  logic        samp_clr, samp_en, done, busy;
  logic [7:0]  grant;
  logic [7:0]  result;

  // Small over-range instance for the saturate/wrap option.
  logic [1:0]  req2;
  logic        samp2;
  logic [0:0]  sel2;
  logic        samp_clr2, samp_en2, done2, busy2;
  logic [1:0]  grant2;
  logic [1:0]  result2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int unsigned ch;
    int unsigned res;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  pat_q[$];
  logic [7:0]  cur_pat;
  exp_t        e;
  int unsigned bit_idx = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          last_done_cyc = 0;
  bit          have_prev = 1'b0;
  bit          spacing_on = 1'b0;
  bit          auto_drop = 1'b1;

  feedback_sample_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .samp_q(samp_q), .sel(sel),
    .samp_clr(samp_clr), .samp_en(samp_en), .grant(grant), .done(done),
    .result(result), .busy(busy)
  );

  feedback_sample_scheduler #(.NCH(2), .SAMPLE_CYCLES(5), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .samp_q(samp2), .sel(sel2),
    .samp_clr(samp_clr2), .samp_en(samp_en2), .grant(grant2), .done(done2),
    .result(result2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count of a window of all-ones samples, saturating or wrapping like the build.
  function automatic int unsigned sat_model(input int unsigned cycles, input int unsigned w);
    int unsigned c;
    int unsigned mx;
    c  = 0;
    mx = (32'd1 << w) - 1;
    for (int unsigned i = 0; i < cycles; i++) begin
`ifdef FB_SCHED_SAT_EN
      if (c < mx) c = c + 1;
`else
      c = (c + 1) & mx;
`endif
    end
    return c;
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({busy, done, samp_en, samp_clr, grant, sel, result});
  endfunction

  // Sampler model and scoreboard consumer.
  always @(negedge clk) begin
    cyc++;
    if (samp_en) begin
      if (bit_idx == 0) begin
        cur_pat = 8'h00;
        if (pat_q.size() != 0) cur_pat = pat_q.pop_front();
      end
      samp_q  = cur_pat[bit_idx[2:0]];
      bit_idx = bit_idx + 1;
    end else begin
      bit_idx = 0;
      samp_q  = 1'($urandom_range(0, 1));
    end
    if (done) begin
      check("sb_nonempty_at_done", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", 32'(result), e.res);
        check("grant", 32'(grant), 32'd1 << e.ch);
        check("sel", 32'(sel), e.ch);
      end
      if (spacing_on) begin
        if (have_prev) check("grant_spacing", 32'(cyc - last_done_cyc), 32'd7);
        have_prev     = 1'b1;
        last_done_cyc = cyc;
      end
      done_cnt++;
      if (auto_drop) req = req & ~grant;
    end
  end

  task automatic push_window(input int unsigned ch, input logic [7:0] pat);
    exp_t x;
    pat_q.push_back(pat);
    x.ch  = ch;
    x.res = $countones(pat[3:0]);
    exp_q.push_back(x);
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    int target;
    target = done_cnt + n;
    for (int i = 0; i < budget && done_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    check(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    rst    = 1'b1;
    req    = '0;
    samp_q = 1'b0;
    req2   = '0;
    samp2  = 1'b1;

    // Reset state, then idle with no requests.
    #1;
    check("reset_outputs", all_outs(), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", all_outs(), 32'd0);
    end

    // Single request on channel 2: exact cycle-by-cycle timing.
    @(negedge clk);
    push_window(2, 8'h0F);
    req = 8'b0000_0100;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      check("timing_ch2", 32'({samp_clr, samp_en, done, sel}),
            32'({(n == 1), (n >= 2 && n <= 5), (n == 6), 3'd2}));
    end

    // All channels held: strict rotation 0..7,0, one grant every 7 cycles.
    do_reset();
    auto_drop  = 1'b0;
    spacing_on = 1'b1;
    have_prev  = 1'b0;
    for (int i = 0; i < 9; i++) push_window(i % 8, 8'($urandom_range(0, 15)));
    @(negedge clk);
    req = 8'hFF;
    wait_dones(9, 120, "rotation_timeout");
    req        = '0;
    spacing_on = 1'b0;
    auto_drop  = 1'b1;
    repeat (3) @(negedge clk);

    // Channel 5 with sample pattern 1,0,1,1.
    push_window(5, 8'b0000_1101);
    req = 8'b0010_0000;
    wait_dones(1, 30, "ch5_timeout");
    repeat (2) @(negedge clk);

    // Reset in the third cycle of a window: async clear, no report.
    pat_q.push_back(8'h0F);
    req   = 8'b0000_0100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (samp_en) found = 1'b1;
    end
    check("abort_window_start", 32'(found), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_async_outputs", all_outs(), 32'd0);
    @(negedge clk);
    check("abort_no_done", 32'({done, grant}), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    push_window(0, 8'($urandom_range(0, 15)));
    push_window(7, 8'($urandom_range(0, 15)));
    req = 8'b1000_0001;
    wait_dones(2, 40, "post_reset_timeout");
    repeat (2) @(negedge clk);

    // Over-range instance: all-ones window of 5 into a 2-bit count.
    req2  = 2'b01;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (done2) begin
        found = 1'b1;
        check("sat_wrap_result", 32'(result2), sat_model(5, 2));
        check("sat_wrap_grant", 32'(grant2), 32'd1);
        req2 = '0;
      end
    end
    check("sat_wrap_timeout", 32'(found), 32'd1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
